// File: rtl/frog_pkg.sv
// Shared definitions for the Frogger game-flow controller: state encodings,
// default frame constants and the speed-select helper.
package frog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DYING = 3'd2,
    ST_HOME  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int DEF_LIVES        = 3;
  localparam int DEF_TIME_FRAMES  = 1800;
  localparam int DEF_DEATH_FRAMES = 60;
  localparam int DEF_HOME_FRAMES  = 30;
  localparam int DEF_MAX_LEVEL    = 7;

  localparam int TIMER_W = 11;
  localparam int PHASE_W = 8;

  localparam logic [9:0] SCORE_MAX = 10'd999;

  // Obstacle speed is one step above the level, pinned at the 3-bit ceiling.
  function automatic logic [2:0] speed_of(input logic [2:0] lvl);
    return (lvl == 3'd7) ? 3'd7 : lvl + 3'd1;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Frame-strobed down-counter with synchronous load; stops at zero and flags it.
module frame_down_counter #(
  parameter int               WIDTH   = 11,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             stb,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= RST_VAL;
    else if (load)
      count <= load_val;
    else if (stb && (count != '0))
      count <= count - ONE;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/frog_game_ctrl.sv
// Game-flow controller: sequences attract/play/death/home/game-over and owns
// lives, level, score and the per-life countdown.
//
//   state | meaning
//   IDLE  | attract screen, counters held at game-start values
//   PLAY  | frog and obstacles moving, life timer running
//   DYING | frozen after a death, frog held at start
//   HOME  | frozen after reaching the top row
//   OVER  | no lives left, final lives/level/score shown
module frog_game_ctrl
  import frog_pkg::*;
#(
  parameter int LIVES        = DEF_LIVES,
  parameter int TIME_FRAMES  = DEF_TIME_FRAMES,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int HOME_FRAMES  = DEF_HOME_FRAMES,
  parameter int MAX_LEVEL    = DEF_MAX_LEVEL
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ani_stb,
  input  logic        i_start_btn,
  input  logic        i_collide,
  input  logic        i_win,
  output logic [2:0]  o_state,
  output logic        o_animate,
  output logic        o_dead,
  output logic [1:0]  o_lives,
  output logic [2:0]  o_level,
  output logic [2:0]  o_speed,
  output logic [9:0]  o_score,
  output logic [10:0] o_timer
);

  localparam logic [1:0]         LIVES_LD = 2'(LIVES);
  localparam logic [2:0]         MAX_LD   = 3'(MAX_LEVEL);
  localparam logic [TIMER_W-1:0] TIME_LD  = TIMER_W'(TIME_FRAMES);
  localparam logic [PHASE_W-1:0] DEATH_LD = PHASE_W'(DEATH_FRAMES);
  localparam logic [PHASE_W-1:0] HOME_LD  = PHASE_W'(HOME_FRAMES);

  state_t             state, next;
  logic               btn_q, start;
  logic               enter_dying, enter_home;
  logic               animate_nxt, dead_nxt;
  logic [1:0]         lives, lives_nxt;
  logic [2:0]         level, level_nxt;
  logic [9:0]         score, score_nxt;
  logic               timer_load, timer_stb, timer_zero;
  logic [TIMER_W-1:0] timer;
  logic               phase_load, phase_stb, phase_zero;
  logic [PHASE_W-1:0] phase_ld_val, phase_cnt;

  assign start = i_start_btn & ~btn_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      btn_q     <= 1'b0;
      lives     <= LIVES_LD;
      level     <= 3'd0;
      score     <= 10'd0;
      o_animate <= 1'b0;
      o_dead    <= 1'b0;
      o_speed   <= 3'd1;
    end else begin
      state     <= next;
      btn_q     <= i_start_btn;
      lives     <= lives_nxt;
      level     <= level_nxt;
      score     <= score_nxt;
      o_animate <= animate_nxt;
      o_dead    <= dead_nxt;
      o_speed   <= speed_of(level_nxt);
    end
  end

  always_comb begin
    next      = state;
    lives_nxt = lives;
    level_nxt = level;
    score_nxt = score;
    case (state)
      ST_IDLE:  if (start) next = ST_PLAY;
      // A collision wins over a same-cycle home arrival.
      ST_PLAY: begin
        if (i_collide || timer_zero) next = ST_DYING;
        else if (i_win)              next = ST_HOME;
      end
      ST_DYING: if (phase_zero) next = (lives == 2'd0) ? ST_OVER : ST_PLAY;
      ST_HOME:  if (phase_zero) next = ST_PLAY;
      ST_OVER:  if (start) next = ST_PLAY;
      default:  next = ST_IDLE;
    endcase

    enter_dying = (state == ST_PLAY) && (next == ST_DYING);
    enter_home  = (state == ST_PLAY) && (next == ST_HOME);
    animate_nxt = (next == ST_PLAY);
    dead_nxt    = (next == ST_DYING);

    if ((state == ST_IDLE) || ((state == ST_OVER) && start)) begin
      lives_nxt = LIVES_LD;
      level_nxt = 3'd0;
      score_nxt = 10'd0;
    end else if (enter_dying) begin
      if (lives != 2'd0) lives_nxt = lives - 2'd1;
    end else if (enter_home) begin
      if (score < SCORE_MAX) score_nxt = score + 10'd1;
      if (level < MAX_LD)    level_nxt = level + 3'd1;
    end
  end

  // Timer reloads on every entry to PLAY and is held full while idle.
  assign timer_load = (state == ST_IDLE) || ((next == ST_PLAY) && (state != ST_PLAY));
  assign timer_stb  = i_ani_stb && (state == ST_PLAY);

  assign phase_load   = enter_dying || enter_home;
  assign phase_ld_val = enter_dying ? DEATH_LD : HOME_LD;
  assign phase_stb    = i_ani_stb && ((state == ST_DYING) || (state == ST_HOME));

  frame_down_counter #(.WIDTH(TIMER_W), .RST_VAL(TIME_LD)) u_life_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (timer_load),
    .load_val (TIME_LD),
    .stb      (timer_stb),
    .count    (timer),
    .zero     (timer_zero)
  );

  frame_down_counter #(.WIDTH(PHASE_W), .RST_VAL('0)) u_phase_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (phase_load),
    .load_val (phase_ld_val),
    .stb      (phase_stb),
    .count    (phase_cnt),
    .zero     (phase_zero)
  );

  assign o_state = state;
  assign o_lives = lives;
  assign o_level = level;
  assign o_score = score;
  assign o_timer = timer;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Scoreboard bench for frog_game_ctrl: stimulus pushes hand-computed expected
// output snapshots, a negedge monitor pops and compares them.
module tb_frog_game_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_DYING = 3'd2;
  localparam logic [2:0] S_HOME  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_ani_stb, i_start_btn, i_collide, i_win;
  logic [2:0]  o_state;
  logic        o_animate, o_dead;
  logic [1:0]  o_lives;
  logic [2:0]  o_level, o_speed;
  logic [9:0]  o_score;
  logic [10:0] o_timer;

  always #5 i_clk = ~i_clk;

  frog_game_ctrl #(
    .LIVES(3), .TIME_FRAMES(1800), .DEATH_FRAMES(60), .HOME_FRAMES(30), .MAX_LEVEL(7)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ani_stb(i_ani_stb),
    .i_start_btn(i_start_btn), .i_collide(i_collide), .i_win(i_win),
    .o_state(o_state), .o_animate(o_animate), .o_dead(o_dead),
    .o_lives(o_lives), .o_level(o_level), .o_speed(o_speed),
    .o_score(o_score), .o_timer(o_timer)
  );

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic        ani;
    logic        dead;
    logic [1:0]  lives;
    logic [2:0]  lvl;
    logic [2:0]  spd;
    logic [9:0]  score;
    logic [10:0] timer;
    bit          tchk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge i_clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (o_state !== mon_e.st || o_animate !== mon_e.ani || o_dead !== mon_e.dead ||
          o_lives !== mon_e.lives || o_level !== mon_e.lvl || o_speed !== mon_e.spd ||
          o_score !== mon_e.score || (mon_e.tchk && o_timer !== mon_e.timer)) begin
        n_fail++;
        $display("FAIL %s: got st=%0d ani=%0b dead=%0b lives=%0d lvl=%0d spd=%0d score=%0d timer=%0d | want st=%0d ani=%0b dead=%0b lives=%0d lvl=%0d spd=%0d score=%0d timer=%0d(chk=%0b)",
                 mon_e.name, o_state, o_animate, o_dead, o_lives, o_level, o_speed, o_score, o_timer,
                 mon_e.st, mon_e.ani, mon_e.dead, mon_e.lives, mon_e.lvl, mon_e.spd, mon_e.score,
                 mon_e.timer, mon_e.tchk);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] st, input logic [1:0] lives,
                            input logic [2:0] lvl, input logic [2:0] spd, input logic [9:0] score,
                            input logic [10:0] timer, input bit tchk);
    exp_t e;
    e.name  = name;
    e.st    = st;
    e.ani   = (st == S_PLAY);
    e.dead  = (st == S_DYING);
    e.lives = lives;
    e.lvl   = lvl;
    e.spd   = spd;
    e.score = score;
    e.timer = timer;
    e.tchk  = tchk;
    sb.push_back(e);
  endtask

  // Let the timer run out, then sit through the 60-frame death freeze.
  task automatic timer_death(input logic [1:0] lives_before, input logic [1:0] lives_after,
                             input logic [2:0] lvl, input logic [2:0] spd, input logic [9:0] score,
                             input logic [2:0] exit_st);
    i_ani_stb = 1'b1;
    repeat (1800) step();
    i_ani_stb = 1'b0;
    expect_out("timer_zero", S_PLAY, lives_before, lvl, spd, score, 11'd0, 1'b1);
    step();
    expect_out("timer_dying", S_DYING, lives_after, lvl, spd, score, 11'd0, 1'b0);
    i_ani_stb = 1'b1;
    repeat (60) step();
    i_ani_stb = 1'b0;
    step();
    expect_out("timer_death_exit", exit_st, lives_after, lvl, spd, score, 11'd1800,
               exit_st == S_PLAY);
  endtask

  task automatic home_check(input logic [1:0] lives, input logic [2:0] lvl,
                            input logic [2:0] spd, input logic [9:0] score);
    i_win = 1'b1;
    step();
    i_win = 1'b0;
    expect_out("home_enter", S_HOME, lives, lvl, spd, score, 11'd0, 1'b0);
    i_ani_stb = 1'b1;
    repeat (30) step();
    i_ani_stb = 1'b0;
    expect_out("home_30", S_HOME, lives, lvl, spd, score, 11'd0, 1'b0);
    step();
    expect_out("home_exit", S_PLAY, lives, lvl, spd, score, 11'd1800, 1'b1);
  endtask

  task automatic fast_home();
    i_win = 1'b1;
    step();
    i_win = 1'b0;
    i_ani_stb = 1'b1;
    repeat (30) step();
    i_ani_stb = 1'b0;
    step();
  endtask

  logic [2:0] lvl_tab [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
  logic [2:0] spd_tab [9] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};

  initial begin
    i_rst_n = 1'b0; i_ani_stb = 1'b0; i_start_btn = 1'b0; i_collide = 1'b0; i_win = 1'b0;
    step(); step();
    expect_out("reset", S_IDLE, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1800, 1'b1);
    i_rst_n = 1'b1;
    step();
    expect_out("idle_hold", S_IDLE, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1800, 1'b1);

    i_start_btn = 1'b1;
    step();
    expect_out("start", S_PLAY, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1800, 1'b1);
    i_start_btn = 1'b0;

    i_ani_stb = 1'b1;
    step();
    i_ani_stb = 1'b0;
    expect_out("timer_dec", S_PLAY, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1799, 1'b1);
    step();
    expect_out("timer_nostb", S_PLAY, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1799, 1'b1);

    i_collide = 1'b1;
    step();
    i_collide = 1'b0;
    expect_out("collide", S_DYING, 2'd2, 3'd0, 3'd1, 10'd0, 11'd0, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      i_ani_stb = 1'b0;
      step();
      i_ani_stb = 1'b1;
      step();
      if (i == 59) expect_out("death_59", S_DYING, 2'd2, 3'd0, 3'd1, 10'd0, 11'd0, 1'b0);
    end
    i_ani_stb = 1'b0;
    expect_out("death_60", S_DYING, 2'd2, 3'd0, 3'd1, 10'd0, 11'd0, 1'b0);
    step();
    expect_out("death_exit", S_PLAY, 2'd2, 3'd0, 3'd1, 10'd0, 11'd1800, 1'b1);

    // Single-cycle win; collide held during HOME must be ignored.
    i_win = 1'b1;
    step();
    i_win = 1'b0;
    expect_out("win", S_HOME, 2'd2, 3'd1, 3'd2, 10'd1, 11'd0, 1'b0);
    i_collide = 1'b1;
    i_ani_stb = 1'b1;
    repeat (30) step();
    i_collide = 1'b0;
    i_ani_stb = 1'b0;
    expect_out("home_hold30", S_HOME, 2'd2, 3'd1, 3'd2, 10'd1, 11'd0, 1'b0);
    step();
    expect_out("home_exit1", S_PLAY, 2'd2, 3'd1, 3'd2, 10'd1, 11'd1800, 1'b1);

    i_win = 1'b1; i_collide = 1'b1;
    step();
    i_win = 1'b0; i_collide = 1'b0;
    expect_out("win_and_collide", S_DYING, 2'd1, 3'd1, 3'd2, 10'd1, 11'd0, 1'b0);
    i_ani_stb = 1'b1;
    repeat (60) step();
    i_ani_stb = 1'b0;
    step();
    expect_out("death2_exit", S_PLAY, 2'd1, 3'd1, 3'd2, 10'd1, 11'd1800, 1'b1);

    i_start_btn = 1'b1;
    step();
    i_start_btn = 1'b0;
    expect_out("start_ignored", S_PLAY, 2'd1, 3'd1, 3'd2, 10'd1, 11'd1800, 1'b1);

    timer_death(2'd1, 2'd0, 3'd1, 3'd2, 10'd1, S_OVER);

    i_collide = 1'b1; i_win = 1'b1; i_ani_stb = 1'b1;
    repeat (5) step();
    i_collide = 1'b0; i_win = 1'b0; i_ani_stb = 1'b0;
    expect_out("over_hold", S_OVER, 2'd0, 3'd1, 3'd2, 10'd1, 11'd0, 1'b0);

    i_start_btn = 1'b1;
    step();
    i_start_btn = 1'b0;
    expect_out("restart", S_PLAY, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1800, 1'b1);

    timer_death(2'd3, 2'd2, 3'd0, 3'd1, 10'd0, S_PLAY);
    timer_death(2'd2, 2'd1, 3'd0, 3'd1, 10'd0, S_PLAY);
    timer_death(2'd1, 2'd0, 3'd0, 3'd1, 10'd0, S_OVER);

    i_start_btn = 1'b1;
    step();
    i_start_btn = 1'b0;
    expect_out("restart2", S_PLAY, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1800, 1'b1);

    for (int k = 0; k < 9; k++)
      home_check(2'd3, lvl_tab[k], spd_tab[k], 10'(k + 1));

    repeat (989) fast_home();
    expect_out("score_998", S_PLAY, 2'd3, 3'd7, 3'd7, 10'd998, 11'd1800, 1'b1);
    home_check(2'd3, 3'd7, 3'd7, 10'd999);
    home_check(2'd3, 3'd7, 3'd7, 10'd999);

    i_collide = 1'b1;
    step();
    i_collide = 1'b0;
    expect_out("dying_enter", S_DYING, 2'd2, 3'd7, 3'd7, 10'd999, 11'd0, 1'b0);
    i_ani_stb = 1'b1;
    repeat (30) step();
    i_ani_stb = 1'b0;
    expect_out("dying_mid", S_DYING, 2'd2, 3'd7, 3'd7, 10'd999, 11'd0, 1'b0);
    i_rst_n = 1'b0;
    i_start_btn = 1'b1;
    step();
    expect_out("rst_mid_dying", S_IDLE, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1800, 1'b1);
    i_rst_n = 1'b1;
    step();
    expect_out("start_after_rst", S_PLAY, 2'd3, 3'd0, 3'd1, 10'd0, 11'd1800, 1'b1);
    i_start_btn = 1'b0;

    repeat (4) if (sb.size() > 0) step();
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: time limit reached with %0d entries pending, want completion", sb.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
